i2c_cmd_arbiter: RTL and testbench

Shares one `i2c_master` command/data interface among `Ports` register-access requesters (e.g. Si570 clock setup, SFP/temperature monitors). It grants requests round-robin and runs each as a complete single-register I2C transaction: a write, or a register-pointer write followed by a repeated-start read. Each transaction returns exactly one response with read data, missed-ACK and timeout status. It sits between the requester blocks and the single `i2c_master` instance driving the board I2C bus.

---
 rtl/i2c_cmd_arbiter.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one i2c_master command/data interface among Ports
// register-access requesters; runs each grant as one complete single-register transaction.
module i2c_cmd_arbiter #(
  parameter int Ports         = 2,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [Ports-1:0]     req_valid,
  output logic [Ports-1:0]     req_ready,
  input  logic [7*Ports-1:0]   req_addr,
  input  logic [8*Ports-1:0]   req_reg,
  input  logic [Ports-1:0]     req_write,
  input  logic [8*Ports-1:0]   req_wdata,
  output logic [Ports-1:0]     rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_nack,
  output logic                 rsp_timeout,
  output logic [6:0]           m_cmd_address,
  output logic                 m_cmd_start,
  output logic                 m_cmd_read,
  output logic                 m_cmd_write,
  output logic                 m_cmd_write_multiple,
  output logic                 m_cmd_stop,
  output logic                 m_cmd_valid,
  input  logic                 m_cmd_ready,
  output logic [7:0]           m_data_in,
  output logic                 m_data_in_valid,
  output logic                 m_data_in_last,
  input  logic                 m_data_in_ready,
  input  logic [7:0]           m_data_out,
  input  logic                 m_data_out_valid,
  output logic                 m_data_out_ready,
  input  logic                 m_busy,
  input  logic                 m_missed_ack,
  output logic                 bus_reset
);

  localparam int unsigned NP = Ports;
  localparam int PW = $clog2(Ports);
  localparam int TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TW-1:0] TLimit   = TW'(TimeoutCycles - 1);
  localparam logic [PW-1:0] LastPort = PW'(Ports - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_WR, DATA_REG, DATA_VAL, CMD_RD, WAIT_RD, WAIT_DONE, RESP
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   last_q, last_d, cur_q, cur_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic            write_q, write_d, nack_q, nack_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [1:0]      wcnt_q, wcnt_d;

  logic [Ports-1:0] req_ready_d, rsp_valid_d;
  logic [7:0]       rsp_rdata_d, data_d;
  logic             rsp_nack_d, rsp_timeout_d, bus_reset_d;
  logic [6:0]       cmd_addr_d;
  logic             cmd_start_d, cmd_read_d, cmd_write_d, cmd_wm_d, cmd_stop_d, cmd_valid_d;
  logic             data_valid_d, data_last_d;

  logic             found, active, timeout_hit, cmd_hs, data_hs;
  logic [PW-1:0]    gnt, cand_idx;
  int unsigned      cand;
  logic [6:0]       sel_addr;
  logic [7:0]       sel_reg, sel_wdata;
  logic             sel_write;

  assign m_data_out_ready = 1'b1;
  assign cmd_hs  = m_cmd_valid && m_cmd_ready;
  assign data_hs = m_data_in_valid && m_data_in_ready;
  assign active  = (state_q != IDLE) && (state_q != RESP);
  assign timeout_hit = active && (tcnt_q == TLimit);

  // Search starts one past the previous winner so every pending port is served in turn.
  always_comb begin
    found    = 1'b0;
    gnt      = last_q;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NP; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NP) cand = cand - NP;
      cand_idx = PW'(cand);
      if (!found && req_valid[cand_idx]) begin
        found = 1'b1;
        gnt   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (PW'(i) == gnt) begin
        sel_addr  = req_addr[7*i +: 7];
        sel_reg   = req_reg[8*i +: 8];
        sel_wdata = req_wdata[8*i +: 8];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    tcnt_d  = tcnt_q;
    wcnt_d  = '0;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = '0;
    rsp_nack_d    = 1'b0;
    rsp_timeout_d = 1'b0;
    bus_reset_d   = 1'b0;
    cmd_addr_d    = '0;
    cmd_start_d   = 1'b0;
    cmd_read_d    = 1'b0;
    cmd_write_d   = 1'b0;
    cmd_wm_d      = 1'b0;
    cmd_stop_d    = 1'b0;
    cmd_valid_d   = 1'b0;
    data_d        = '0;
    data_valid_d  = 1'b0;
    data_last_d   = 1'b0;

    if (active) begin
      tcnt_d = tcnt_q + 1'b1;
      if (m_missed_ack) nack_d = 1'b1;
    end

    // Each valid rises one cycle after entering its state and drops on the handshake edge.
    if (timeout_hit) begin
      rdata_d     = '0;
      bus_reset_d = 1'b1;
      state_d     = RESP;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            req_ready_d[gnt] = 1'b1;
            cur_d   = gnt;
            last_d  = gnt;
            addr_d  = sel_addr;
            reg_d   = sel_reg;
            write_d = sel_write;
            wdata_d = sel_wdata;
            rdata_d = '0;
            nack_d  = 1'b0;
            tcnt_d  = '0;
            state_d = CMD_WR;
          end
        end
        CMD_WR: begin
          if (cmd_hs) begin
            state_d = DATA_REG;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = addr_q;
            cmd_start_d = 1'b1;
            cmd_wm_d    = write_q;
            cmd_stop_d  = write_q;
            cmd_write_d = !write_q;
          end
        end
        DATA_REG: begin
          if (data_hs) begin
            state_d = write_q ? DATA_VAL : CMD_RD;
          end else begin
            data_valid_d = 1'b1;
            data_d       = reg_q;
            data_last_d  = !write_q;
          end
        end
        DATA_VAL: begin
          if (data_hs) begin
            state_d = WAIT_DONE;
          end else begin
            data_valid_d = 1'b1;
            data_d       = wdata_q;
            data_last_d  = 1'b1;
          end
        end
        CMD_RD: begin
          if (cmd_hs) begin
            state_d = WAIT_RD;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = addr_q;
            cmd_start_d = 1'b1;
            cmd_read_d  = 1'b1;
            cmd_stop_d  = 1'b1;
          end
        end
        WAIT_RD: begin
          if (m_data_out_valid) begin
            rdata_d = m_data_out;
            state_d = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wcnt_q == 2'd2 && !m_busy) state_d = RESP;
          else wcnt_d = (wcnt_q == 2'd2) ? 2'd2 : wcnt_q + 2'd1;
        end
        RESP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d == RESP && state_q != RESP) begin
      rsp_valid_d[cur_q] = 1'b1;
      rsp_rdata_d   = (write_q || timeout_hit) ? 8'h00 : rdata_d;
      rsp_nack_d    = nack_d;
      rsp_timeout_d = timeout_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LastPort;
      cur_q   <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      tcnt_q  <= '0;
      wcnt_q  <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      bus_reset   <= 1'b0;
      m_cmd_address        <= '0;
      m_cmd_start          <= 1'b0;
      m_cmd_read           <= 1'b0;
      m_cmd_write          <= 1'b0;
      m_cmd_write_multiple <= 1'b0;
      m_cmd_stop           <= 1'b0;
      m_cmd_valid          <= 1'b0;
      m_data_in            <= '0;
      m_data_in_valid      <= 1'b0;
      m_data_in_last       <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      tcnt_q  <= tcnt_d;
      wcnt_q  <= wcnt_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_nack    <= rsp_nack_d;
      rsp_timeout <= rsp_timeout_d;
      bus_reset   <= bus_reset_d;
      m_cmd_address        <= cmd_addr_d;
      m_cmd_start          <= cmd_start_d;
      m_cmd_read           <= cmd_read_d;
      m_cmd_write          <= cmd_write_d;
      m_cmd_write_multiple <= cmd_wm_d;
      m_cmd_stop           <= cmd_stop_d;
      m_cmd_valid          <= cmd_valid_d;
      m_data_in            <= data_d;
      m_data_in_valid      <= data_valid_d;
      m_data_in_last       <= data_last_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a small i2c_master stand-in that logs
// command/data handshakes and returns read data, busy and missed-ACK status.
module tb_i2c_cmd_arbiter;

  logic        clk, reset;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [13:0] req_addr;
  logic [15:0] req_reg, req_wdata;
  logic [7:0]  rsp_rdata;
  logic        rsp_nack, rsp_timeout;
  logic [6:0]  m_cmd_address;
  logic        m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop;
  logic        m_cmd_valid, m_cmd_ready;
  logic [7:0]  m_data_in, m_data_out;
  logic        m_data_in_valid, m_data_in_last, m_data_in_ready;
  logic        m_data_out_valid, m_data_out_ready, m_busy, m_missed_ack, bus_reset;

  int checks = 0;
  int errors = 0;

  logic       nack_mode = 1'b0;
  int         read_delay = 3;
  logic [7:0] slave_byte = 8'h00;
  int         busy_cnt, rd_cnt;
  logic [11:0] cmd_log[$];
  logic [8:0]  data_log[$];

  logic [1:0] got_ready, got_rsp;
  logic [7:0] got_rdata;
  logic       got_nack, got_to;

  i2c_cmd_arbiter #(.Ports(2), .TimeoutCycles(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_reg(req_reg),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
    .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple), .m_cmd_stop(m_cmd_stop),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_data_in(m_data_in), .m_data_in_valid(m_data_in_valid), .m_data_in_last(m_data_in_last),
    .m_data_in_ready(m_data_in_ready),
    .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid), .m_data_out_ready(m_data_out_ready),
    .m_busy(m_busy), .m_missed_ack(m_missed_ack), .bus_reset(bus_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    m_data_out_valid <= 1'b0;
    m_missed_ack     <= 1'b0;
    if (reset) begin
      busy_cnt <= 0;
      rd_cnt   <= 0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (rd_cnt != 0) begin
        rd_cnt <= rd_cnt - 1;
        if (rd_cnt == 1) begin
          m_data_out_valid <= 1'b1;
          m_data_out       <= slave_byte;
          busy_cnt         <= 4;
        end
      end
      if (m_cmd_valid && m_cmd_ready) begin
        cmd_log.push_back({m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
                           m_cmd_stop, m_cmd_address});
        busy_cnt <= 6;
        if (m_cmd_read) rd_cnt <= read_delay;
        if (nack_mode) m_missed_ack <= 1'b1;
      end
      if (m_data_in_valid && m_data_in_ready) begin
        data_log.push_back({m_data_in_last, m_data_in});
        busy_cnt <= 6;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [6:0] a, input logic [7:0] r,
                         input logic w, input logic [7:0] d);
    req_addr[7*p +: 7]  = a;
    req_reg[8*p +: 8]   = r;
    req_wdata[8*p +: 8] = d;
    req_write[p]        = w;
    req_valid[p]        = 1'b1;
  endtask

  task automatic wait_ready_any();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req_ready == 2'b00 && k < 200);
    got_ready = req_ready;
  endtask

  task automatic wait_rsp();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rsp_valid == 2'b00 && k < 400);
    got_rsp   = rsp_valid;
    got_rdata = rsp_rdata;
    got_nack  = rsp_nack;
    got_to    = rsp_timeout;
  endtask

  initial begin
    int k;
    int cnt;
    logic [1:0] exp;
    reset = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_reg = '0; req_wdata = '0;
    m_cmd_ready = 1'b1;
    m_data_in_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_cmd_valid", 32'(m_cmd_valid), 0);
    check("rst_data_valid", 32'(m_data_in_valid), 0);
    check("rst_bus_reset", 32'(bus_reset), 0);
    check("data_out_ready", 32'(m_data_out_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // single write, port 0
    cmd_log.delete(); data_log.delete();
    set_req(0, 7'h55, 8'd135, 1'b1, 8'h01);
    wait_ready_any();
    check("wr_grant", 32'(got_ready), 32'b01);
    check("wr_cmd_valid_lag", 32'(m_cmd_valid), 0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("wr_cmd_valid_rise", 32'(m_cmd_valid), 1);
    check("wr_cmd_addr", 32'(m_cmd_address), 32'h55);
    wait_rsp();
    check("wr_rsp_valid", 32'(got_rsp), 32'b01);
    check("wr_rsp_nack", 32'(got_nack), 0);
    check("wr_rsp_timeout", 32'(got_to), 0);
    check("wr_rsp_rdata", 32'(got_rdata), 0);
    check("wr_cmd_count", 32'(cmd_log.size()), 1);
    check("wr_cmd0", 32'(cmd_log[0]), 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'h55}));
    check("wr_data_count", 32'(data_log.size()), 2);
    check("wr_data0", 32'(data_log[0]), 32'h087);
    check("wr_data1", 32'(data_log[1]), 32'h101);

    // single read, port 1
    @(negedge clk);
    cmd_log.delete(); data_log.delete();
    slave_byte = 8'hA3; read_delay = 3;
    set_req(1, 7'h50, 8'd7, 1'b0, 8'h00);
    wait_ready_any();
    check("rd_grant", 32'(got_ready), 32'b10);
    req_valid[1] = 1'b0;
    wait_rsp();
    check("rd_rsp_valid", 32'(got_rsp), 32'b10);
    check("rd_rsp_rdata", 32'(got_rdata), 32'hA3);
    check("rd_rsp_nack", 32'(got_nack), 0);
    check("rd_cmd_count", 32'(cmd_log.size()), 2);
    check("rd_cmd0", 32'(cmd_log[0]), 32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h50}));
    check("rd_cmd1", 32'(cmd_log[1]), 32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h50}));
    check("rd_data_count", 32'(data_log.size()), 1);
    check("rd_data0", 32'(data_log[0]), 32'h107);

    // round-robin with both ports requesting continuously
    @(negedge clk);
    set_req(0, 7'h11, 8'h20, 1'b1, 8'h5A);
    set_req(1, 7'h22, 8'h30, 1'b1, 8'hA5);
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready_any();
      check("rr_grant", 32'(got_ready), 32'(exp));
      if (t == 3) req_valid = '0;
      wait_rsp();
      check("rr_rsp", 32'(got_rsp), 32'(exp));
    end

    // missed ACK: completes normally with nack set, next transaction clean
    @(negedge clk);
    nack_mode = 1'b1;
    set_req(0, 7'h33, 8'h01, 1'b1, 8'h02);
    wait_ready_any();
    req_valid[0] = 1'b0;
    wait_rsp();
    check("nack_rsp_valid", 32'(got_rsp), 32'b01);
    check("nack_flag", 32'(got_nack), 1);
    check("nack_timeout", 32'(got_to), 0);
    @(negedge clk);
    nack_mode = 1'b0;
    set_req(1, 7'h33, 8'h01, 1'b1, 8'h02);
    wait_ready_any();
    req_valid[1] = 1'b0;
    wait_rsp();
    check("post_nack_flag", 32'(got_nack), 0);

    // timeout with the command stream stalled
    @(negedge clk);
    m_cmd_ready = 1'b0;
    set_req(0, 7'h44, 8'h05, 1'b0, 8'h00);
    wait_ready_any();
    check("to_grant", 32'(got_ready), 32'b01);
    req_valid[0] = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_reset && k < 300);
    check("to_cycle", 32'(k), 100);
    check("to_rsp_valid", 32'(rsp_valid), 32'b01);
    check("to_flag", 32'(rsp_timeout), 1);
    check("to_rdata", 32'(rsp_rdata), 0);
    @(negedge clk);
    check("to_bus_reset_pulse", 32'(bus_reset), 0);
    check("to_cmd_valid_drop", 32'(m_cmd_valid), 0);
    m_cmd_ready = 1'b1;
    set_req(1, 7'h45, 8'h06, 1'b1, 8'h07);
    wait_ready_any();
    check("after_to_grant", 32'(got_ready), 32'b10);
    req_valid[1] = 1'b0;
    wait_rsp();
    check("after_to_rsp", 32'(got_rsp), 32'b10);
    check("after_to_flag", 32'(got_to), 0);

    // reset during WAIT_RD
    @(negedge clk);
    cmd_log.delete(); data_log.delete();
    read_delay = 40;
    set_req(0, 7'h66, 8'h09, 1'b0, 8'h00);
    wait_ready_any();
    req_valid[0] = 1'b0;
    k = 0;
    while (cmd_log.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_rd_cmds", 32'(cmd_log.size()), 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_cmd_valid", 32'(m_cmd_valid), 0);
    check("mid_rst_data_valid", 32'(m_data_in_valid), 0);
    check("mid_rst_bus_reset", 32'(bus_reset), 0);
    reset = 1'b0;
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) cnt++;
    end
    check("mid_rst_no_rsp", 32'(cnt), 0);
    read_delay = 3;
    set_req(0, 7'h12, 8'h01, 1'b1, 8'h01);
    set_req(1, 7'h13, 8'h02, 1'b1, 8'h02);
    wait_ready_any();
    check("post_rst_grant", 32'(got_ready), 32'b01);
    req_valid = '0;
    wait_rsp();
    check("post_rst_rsp", 32'(got_rsp), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
